// File: rtl/cpu_run_ctrl_if.sv
// Stimulus/status bundle between the bench or board and cpu_run_ctrl.
// Breakpoint signals exist in every build; only CPU_RUN_CTRL_BREAK_EN builds use them.
interface cpu_run_ctrl_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
);
    logic             RUN_N;
    logic             STEP_N;
    logic [DIV_W-1:0] DIV;
    logic [PC_W-1:0]  PC;
    logic [PC_W-1:0]  BRK_ADDR;
    logic             BRK_ENA;
    logic             CPU_RESET;
    logic             CPU_CE;
    logic             MEM_CE;
    logic             RUNNING;
    logic [CNT_W-1:0] CYCLE_CNT;

    modport master (
        output RUN_N, STEP_N, DIV, PC, BRK_ADDR, BRK_ENA,
        input  CPU_RESET, CPU_CE, MEM_CE, RUNNING, CYCLE_CNT
    );

    modport slave (
        input  RUN_N, STEP_N, DIV, PC, BRK_ADDR, BRK_ENA,
        output CPU_RESET, CPU_CE, MEM_CE, RUNNING, CYCLE_CNT
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/reset controller for mcpu: stretched CPU reset, debounced run/step buttons, CPU/MEM clock enables.
// Optional breakpoint halt is enabled by defining CPU_RUN_CTRL_BREAK_EN.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int DEB_CYCLES = 8,
    parameter int DIV_W      = 8,
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    cpu_run_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALT     = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } state_t;

    logic [1:0] btn_raw_s;
    logic [1:0] press_s;
    logic       run_press_s;
    logic       step_press_s;
    logic       brk_hit_s;

    assign btn_raw_s    = {bus.STEP_N, bus.RUN_N};
    assign run_press_s  = press_s[0];
    assign step_press_s = press_s[1];

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             sync1_r;
        logic             sync2_r;
        logic             deb_r;
        logic             press_r;
        logic [DEB_W-1:0] deb_cnt_r;

        // Synchronise one button and accept a level only after DEB_CYCLES stable samples
        always_ff @(posedge CLK) begin
            if (RESET) begin
                sync1_r   <= 1'b1;
                sync2_r   <= 1'b1;
                deb_r     <= 1'b1;
                press_r   <= 1'b0;
                deb_cnt_r <= '0;
            end else begin
                sync1_r <= btn_raw_s[i];
                sync2_r <= sync1_r;
                press_r <= 1'b0;
                if (sync2_r != deb_r) begin
                    if (deb_cnt_r == DEB_LAST) begin
                        deb_r     <= sync2_r;
                        deb_cnt_r <= '0;
                        press_r   <= ~sync2_r;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + 1'b1;
                    end
                end else begin
                    deb_cnt_r <= '0;
                end
            end
        end

        assign press_s[i] = press_r;
    end

`ifdef CPU_RUN_CTRL_BREAK_EN
    assign brk_hit_s = bus.BRK_ENA & (bus.PC == bus.BRK_ADDR);
`else
    logic unused_brk_s;
    assign unused_brk_s = ^{bus.PC, bus.BRK_ADDR, bus.BRK_ENA};
    assign brk_hit_s    = 1'b0;
`endif

    state_t            state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [DIV_W-1:0]  div_lat_r;
    logic              cpu_reset_r;
    logic              cpu_ce_r;
    logic              mem_ce_r;
    logic              running_r;
    logic [CNT_W-1:0]  cycle_cnt_r;

    // Run-mode FSM with registered clock-enable, status and cycle-count outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_RST_HOLD;
            hold_cnt_r  <= HOLD_INIT;
            div_cnt_r   <= '0;
            div_lat_r   <= '0;
            cpu_reset_r <= 1'b1;
            cpu_ce_r    <= 1'b0;
            mem_ce_r    <= 1'b0;
            running_r   <= 1'b0;
            cycle_cnt_r <= '0;
        end else begin
            mem_ce_r <= cpu_ce_r;
            cpu_ce_r <= 1'b0;
            case (state_r)
                ST_RST_HOLD: begin
                    // leave on the edge the hold count reaches zero
                    if (hold_cnt_r <= HOLD_ONE) begin
                        hold_cnt_r  <= '0;
                        cpu_reset_r <= 1'b0;
                        state_r     <= ST_HALT;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 1'b1;
                    end
                end
                ST_HALT: begin
                    if (run_press_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        div_cnt_r <= '0;
                        div_lat_r <= bus.DIV;
                    end else if (step_press_s) begin
                        state_r     <= ST_STEP;
                        cpu_ce_r    <= 1'b1;
                        cycle_cnt_r <= cycle_cnt_r + 1'b1;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_r <= ST_HALT;
                end
                ST_RUN: begin
                    if (run_press_s) begin
                        state_r   <= ST_HALT;
                        running_r <= 1'b0;
                        div_cnt_r <= '0;
                    end else if (div_cnt_r == div_lat_r) begin
                        // period ends: re-latch DIV so a change applies to the next period only
                        div_cnt_r <= '0;
                        div_lat_r <= bus.DIV;
                        if (brk_hit_s) begin
                            state_r   <= ST_HALT;
                            running_r <= 1'b0;
                        end else begin
                            cpu_ce_r    <= 1'b1;
                            cycle_cnt_r <= cycle_cnt_r + 1'b1;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_RST_HOLD;
                    hold_cnt_r  <= HOLD_INIT;
                    cpu_reset_r <= 1'b1;
                    running_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CPU_RESET = cpu_reset_r;
    assign bus.CPU_CE    = cpu_ce_r;
    assign bus.MEM_CE    = mem_ce_r;
    assign bus.RUNNING   = running_r;
    assign bus.CYCLE_CNT = cycle_cnt_r;
endmodule
